regfile_write_queue: RTL and testbench
======================================

Name: regfile_write_queue

Overview:
- Small FIFO of pending register writes (address, data) sitting directly upstream of the 32 reg_group_32 instances in the register file.
- Accepts write-back requests with a valid/ready handshake and drains one entry per cycle.
- Converts each drained entry into a one-hot per-register enable plus a shared data bus driving the en/d pins of the register groups.
- A lookup port returns the youngest pending value for an address so readers see writes still queued.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2
- ADDR_W, 5, register address width; 2^ADDR_W = 32 register groups
- DATA_W, 32, register data width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  write-back request present
- in_ready  out  1  queue can accept; equals !full
- in_addr  in  ADDR_W  destination register
- in_data  in  DATA_W  value to write
- drain_stall  in  1  high = hold head entry, no write this cycle
- wr_en  out  2^ADDR_W  one-hot enable to register groups; bit k drives en of register k
- wr_data  out  DATA_W  data to all register groups' d inputs
- lk_addr  in  ADDR_W  lookup address
- lk_hit  out  1  a pending entry targets lk_addr
- lk_data  out  DATA_W  data of youngest matching pending entry
- count  out  clog2(DEPTH)+1  occupancy
- empty  out  1  count == 0

Behaviour:
- Reset: clk and rst are the only clock and reset; rst low asynchronously clears head, tail and count to 0 and every entry-valid bit to 0. While rst is low: wr_en=0, wr_data=0, lk_hit=0, lk_data=0, count=0, empty=1, in_ready=1. Reset mid-drain drops all pending entries with no partial write.
- Enqueue: when in_valid & in_ready at an edge, store {in_addr, in_data} at tail; tail wraps modulo DEPTH.
  - in_addr==0 is accepted (handshake completes) but not stored; count is unchanged. Register 0 is never written.
- Full: count==DEPTH drives in_ready=0. This holds even if a dequeue occurs in the same cycle; no same-cycle pass-through when full.
- Drain (combinational from head): when !empty & !drain_stall, wr_en = one-hot(head.addr) and wr_data = head.data. The entry retires at that edge and head wraps modulo DEPTH. When empty or stalled, wr_en=0 and wr_data=0.
- Latency: an entry accepted at edge N can produce wr_en in the cycle after edge N, at the earliest. No bypass of an empty queue straight to wr_en.
- Simultaneous enqueue and dequeue (not full): count unchanged, both pointers advance.
- Ordering: strict FIFO. Two queued writes to the same register both drain in order, so the final value is the younger one.
- Lookup (combinational): scan valid entries from tail-1 back to head; the first match gives lk_hit=1 and lk_data.
  - lk_addr==0 always gives lk_hit=0.
  - An entry retiring this cycle still counts as a hit this cycle.
  - The entry being enqueued this cycle is not visible until the next cycle.
- Invariants: wr_en has at most one bit set, and wr_en[0] is never set.
- Arithmetic: pointers are clog2(DEPTH) bits with natural wrap. count is one bit wider and never exceeds DEPTH or underflows.

Decomposition:
- Shared package/header: ADDR_W, DATA_W, NUM_REGS=32, REG_ZERO=0 constants; wq_entry_t record {valid, addr, data}.
- Sub-module decoder_onehot (ADDR_W → 2^ADDR_W, with enable input) generates wr_en. It is reused by the register file's write decode.
- Storage is a flop array inside the queue; no separate FIFO module.

Test Plan:
- Reset then single write: enqueue (addr 5, 0xDEADBEEF) → next cycle wr_en=0x00000020, wr_data=0xDEADBEEF; following cycle wr_en=0, empty=1.
- Fill/full: four enqueues to r1..r4 with drain_stall=1 → count=4, in_ready=0; fifth request not accepted. Release stall → r1,r2,r3,r4 written on four consecutive cycles; in_ready=1 after first drain.
- Register zero: enqueue (addr 0, 0x1234) → handshake completes, count stays 0, wr_en stays 0; lookup lk_addr=0 → lk_hit=0.
- Lookup youngest: stall, enqueue (r7, 0xA), (r7, 0xB) → lk_addr=7 gives lk_hit=1, lk_data=0xB. Drain → r7 written 0xA then 0xB.
- Simultaneous enq/deq with wrap: keep count=2 while enqueuing and draining for 10 cycles → pointers wrap, count stays 2, output order matches input order.
- Async reset mid-operation: 3 entries queued, assert rst between edges → wr_en=0, count=0, empty=1 immediately; after release nothing drains.

Source files
------------

// File: rtl/regfile_write_queue_pkg.sv
// Shared constants and the queue entry record for the register-file write queue.
// Widths match the 32-entry register file this queue feeds.
package regfile_write_queue_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wq_entry_t;

endpackage

// File: rtl/regfile_write_queue_if.sv
// Bus bundle between the write-back source, the register groups and lookup readers.
// The master side is the producer/reader; the slave side is the queue itself.
interface regfile_write_queue_if #(
  parameter int DEPTH = 4
) ();
  import regfile_write_queue_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                in_valid;
  logic                in_ready;
  logic [ADDR_W-1:0]   in_addr;
  logic [DATA_W-1:0]   in_data;
  logic                drain_stall;
  logic [NUM_REGS-1:0] wr_en;
  logic [DATA_W-1:0]   wr_data;
  logic [ADDR_W-1:0]   lk_addr;
  logic                lk_hit;
  logic [DATA_W-1:0]   lk_data;
  logic [CNT_W-1:0]    count;
  logic                empty;

  modport master (
    output in_valid, in_addr, in_data, drain_stall, lk_addr,
    input  in_ready, wr_en, wr_data, lk_hit, lk_data, count, empty
  );

  modport slave (
    input  in_valid, in_addr, in_data, drain_stall, lk_addr,
    output in_ready, wr_en, wr_data, lk_hit, lk_data, count, empty
  );

endinterface

// File: rtl/regfile_write_queue_decoder_onehot.sv
// Enabled binary-to-one-hot decoder; shared with the register file's own write decode.
module decoder_onehot #(
  parameter int IN_W = 5
) (
  input  logic                   i_en,
  input  logic [IN_W-1:0]        i_sel,
  output logic [(1 << IN_W)-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_sel] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_queue.sv
// Pending register-write FIFO in front of the register groups: drains one entry per cycle
// as a one-hot enable plus shared data, and exposes the youngest queued value per address.
module regfile_write_queue
  import regfile_write_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_write_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  wq_entry_t        r_mem [DEPTH];

  logic                w_full;
  logic                w_empty;
  logic                w_enq;
  logic                w_deq;
  wq_entry_t           w_head_entry;
  logic [NUM_REGS-1:0] w_wr_en;
  logic                w_lk_hit;
  logic [DATA_W-1:0]   w_lk_data;

  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_head_entry = r_mem[r_head];

  // Writes to register 0 complete the handshake but are discarded.
  assign w_enq = bus.in_valid & ~w_full & (bus.in_addr != REG_ZERO);
  assign w_deq = ~w_empty & ~bus.drain_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      // Enqueue and dequeue never share a slot: enqueue is blocked when full,
      // dequeue is blocked when empty.
      if (w_enq) begin
        r_mem[r_tail] <= '{valid: 1'b1, addr: bus.in_addr, data: bus.in_data};
        r_tail        <= r_tail + PTR_W'(1);
      end
      if (w_deq) begin
        r_mem[r_head].valid <= 1'b0;
        r_head              <= r_head + PTR_W'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  decoder_onehot #(
    .IN_W (ADDR_W)
  ) u_wr_dec (
    .i_en     (w_deq),
    .i_sel    (w_head_entry.addr),
    .o_onehot (w_wr_en)
  );

  // Walk oldest to youngest so the last match wins; the head entry still
  // counts while it is retiring because its valid bit clears only at the edge.
  always_comb begin
    w_lk_hit  = 1'b0;
    w_lk_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_mem[r_head + PTR_W'(i)].valid &&
          (r_mem[r_head + PTR_W'(i)].addr == bus.lk_addr) &&
          (bus.lk_addr != REG_ZERO)) begin
        w_lk_hit  = 1'b1;
        w_lk_data = r_mem[r_head + PTR_W'(i)].data;
      end
    end
  end

  assign bus.in_ready = ~w_full;
  assign bus.wr_en    = w_wr_en;
  assign bus.wr_data  = w_deq ? w_head_entry.data : '0;
  assign bus.lk_hit   = w_lk_hit;
  assign bus.lk_data  = w_lk_data;
  assign bus.count    = r_count;
  assign bus.empty    = w_empty;

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue: single write, full/drain, register zero,
// youngest-match lookup, wrapping simultaneous enqueue/dequeue, async reset mid-drain.
module tb_regfile_write_queue;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  regfile_write_queue_if #(.DEPTH(4)) bus ();

  regfile_write_queue #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.in_valid = v;
    bus.in_addr  = a;
    bus.in_data  = d;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_addr     = '0;
    bus.in_data     = '0;
    bus.drain_stall = 1'b0;
    bus.lk_addr     = 5'd5;

    // Reset state
    @(negedge clk); #1;
    chk("rst_wr_en",    64'(bus.wr_en),    64'h0);
    chk("rst_wr_data",  64'(bus.wr_data),  64'h0);
    chk("rst_lk_hit",   64'(bus.lk_hit),   64'h0);
    chk("rst_lk_data",  64'(bus.lk_data),  64'h0);
    chk("rst_count",    64'(bus.count),    64'h0);
    chk("rst_empty",    64'(bus.empty),    64'h1);
    chk("rst_in_ready", 64'(bus.in_ready), 64'h1);
    @(negedge clk); rst_n = 1'b1;

    // Single write, no bypass, one-cycle latency
    @(negedge clk); drive(1'b1, 5'd5, 32'hDEADBEEF); #1;
    chk("t1_no_bypass",    64'(bus.wr_en),  64'h0);
    chk("t1_enq_invisible", 64'(bus.lk_hit), 64'h0);
    @(negedge clk); bus.in_valid = 1'b0; #1;
    chk("t1_wr_en",   64'(bus.wr_en),   64'h0000_0020);
    chk("t1_wr_data", 64'(bus.wr_data), 64'hDEADBEEF);
    chk("t1_count",   64'(bus.count),   64'h1);
    chk("t1_lk_hit",  64'(bus.lk_hit),  64'h1);
    chk("t1_lk_data", 64'(bus.lk_data), 64'hDEADBEEF);
    @(negedge clk); #1;
    chk("t1_after_wr_en",   64'(bus.wr_en),   64'h0);
    chk("t1_after_wr_data", 64'(bus.wr_data), 64'h0);
    chk("t1_after_empty",   64'(bus.empty),   64'h1);

    // Fill under stall, reject fifth, drain in order
    bus.drain_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); drive(1'b1, 5'(k + 1), 32'(8'h11 * (k + 1)));
    end
    @(negedge clk); drive(1'b1, 5'd9, 32'h99); #1;
    chk("t2_full_count", 64'(bus.count),    64'h4);
    chk("t2_full_ready", 64'(bus.in_ready), 64'h0);
    chk("t2_stall_wr",   64'(bus.wr_en),    64'h0);
    @(negedge clk); bus.in_valid = 1'b0; bus.drain_stall = 1'b0; #1;
    chk("t2_rej_count",  64'(bus.count),    64'h4);
    chk("t2_full_deq_ready", 64'(bus.in_ready), 64'h0);
    chk("t2_d0_wr_en",   64'(bus.wr_en),    64'h2);
    chk("t2_d0_wr_data", 64'(bus.wr_data),  64'h11);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); #1;
      chk($sformatf("t2_d%0d_wr_en", k),   64'(bus.wr_en),    64'h1 << (k + 1));
      chk($sformatf("t2_d%0d_wr_data", k), 64'(bus.wr_data),  64'(8'h11 * (k + 1)));
      chk($sformatf("t2_d%0d_count", k),   64'(bus.count),    64'(4 - k));
      chk($sformatf("t2_d%0d_ready", k),   64'(bus.in_ready), 64'h1);
    end
    @(negedge clk); #1;
    chk("t2_drained_empty", 64'(bus.empty), 64'h1);
    chk("t2_drained_wr_en", 64'(bus.wr_en), 64'h0);

    // Register zero accepted, dropped
    @(negedge clk); drive(1'b1, 5'd0, 32'h1234); bus.lk_addr = 5'd0; #1;
    chk("t3_r0_ready", 64'(bus.in_ready), 64'h1);
    @(negedge clk); bus.in_valid = 1'b0; #1;
    chk("t3_r0_count", 64'(bus.count),  64'h0);
    chk("t3_r0_wr_en", 64'(bus.wr_en),  64'h0);
    chk("t3_r0_empty", 64'(bus.empty),  64'h1);
    chk("t3_r0_lk",    64'(bus.lk_hit), 64'h0);

    // Youngest-match lookup, ordered drain of same register
    bus.drain_stall = 1'b1;
    @(negedge clk); drive(1'b1, 5'd7, 32'hA);
    @(negedge clk); drive(1'b1, 5'd7, 32'hB);
    @(negedge clk); bus.in_valid = 1'b0; bus.lk_addr = 5'd7; #1;
    chk("t4_lk_hit",  64'(bus.lk_hit),  64'h1);
    chk("t4_lk_data", 64'(bus.lk_data), 64'hB);
    chk("t4_count",   64'(bus.count),   64'h2);
    bus.lk_addr = 5'd3; #1;
    chk("t4_lk_miss", 64'(bus.lk_hit), 64'h0);
    bus.lk_addr = 5'd7;
    @(negedge clk); bus.drain_stall = 1'b0; #1;
    chk("t4_d0_wr_en",   64'(bus.wr_en),   64'h80);
    chk("t4_d0_wr_data", 64'(bus.wr_data), 64'hA);
    chk("t4_d0_lk_data", 64'(bus.lk_data), 64'hB);
    @(negedge clk); #1;
    chk("t4_d1_wr_en",   64'(bus.wr_en),   64'h80);
    chk("t4_d1_wr_data", 64'(bus.wr_data), 64'hB);
    chk("t4_retire_hit", 64'(bus.lk_hit),  64'h1);
    chk("t4_retire_data", 64'(bus.lk_data), 64'hB);
    @(negedge clk); #1;
    chk("t4_done_hit",   64'(bus.lk_hit), 64'h0);
    chk("t4_done_empty", 64'(bus.empty),  64'h1);

    // Steady count of 2 with simultaneous enqueue/dequeue across pointer wrap
    bus.drain_stall = 1'b1;
    @(negedge clk); drive(1'b1, 5'd1, 32'h100);
    @(negedge clk); drive(1'b1, 5'd2, 32'h101);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk); bus.drain_stall = 1'b0; drive(1'b1, 5'(j + 3), 32'(32'h102 + j)); #1;
      chk($sformatf("t5_%0d_wr_en", j),   64'(bus.wr_en),    64'h1 << (j + 1));
      chk($sformatf("t5_%0d_wr_data", j), 64'(bus.wr_data),  64'(32'h100 + j));
      chk($sformatf("t5_%0d_count", j),   64'(bus.count),    64'h2);
      chk($sformatf("t5_%0d_ready", j),   64'(bus.in_ready), 64'h1);
    end
    @(negedge clk); bus.in_valid = 1'b0; #1;
    chk("t5_tail0_wr_en",   64'(bus.wr_en),   64'h1 << 11);
    chk("t5_tail0_wr_data", 64'(bus.wr_data), 64'h10A);
    @(negedge clk); #1;
    chk("t5_tail1_wr_en",   64'(bus.wr_en),   64'h1 << 12);
    chk("t5_tail1_wr_data", 64'(bus.wr_data), 64'h10B);
    @(negedge clk); #1;
    chk("t5_empty", 64'(bus.empty), 64'h1);

    // Async reset between edges while draining
    bus.drain_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drive(1'b1, 5'(20 + k), 32'(32'h200 + k));
    end
    @(negedge clk); bus.in_valid = 1'b0; bus.drain_stall = 1'b0; bus.lk_addr = 5'd21; #1;
    chk("t6_pre_wr_en", 64'(bus.wr_en), 64'h1 << 20);
    chk("t6_pre_count", 64'(bus.count), 64'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_wr_en",   64'(bus.wr_en),    64'h0);
    chk("t6_rst_wr_data", 64'(bus.wr_data),  64'h0);
    chk("t6_rst_count",   64'(bus.count),    64'h0);
    chk("t6_rst_empty",   64'(bus.empty),    64'h1);
    chk("t6_rst_ready",   64'(bus.in_ready), 64'h1);
    chk("t6_rst_lk_hit",  64'(bus.lk_hit),   64'h0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk($sformatf("t6_post%0d_wr_en", k), 64'(bus.wr_en), 64'h0);
      chk($sformatf("t6_post%0d_empty", k), 64'(bus.empty), 64'h1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
